// File: rtl/Types.sv
`default_nettype none
// ============================================================================
//  Module      : Types
//  Description : Scene primitive types shared by the scheduler and workers.
//  Revision    : 1.0  initial release
// ============================================================================
package Types;

    typedef struct packed {
        logic signed [11:0] x;
        logic signed [11:0] y;
        logic        [11:0] radius;
        logic        [11:0] colour;
    } Circle;

endpackage
`default_nettype wire

// File: rtl/raytracing_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : raytracing_scheduler
//  Description : Launches the worker bank span by span over the screen and
//                drains the finished colour buffers into the framebuffer.
//  Revision    : 1.0  initial release
// ============================================================================
module raytracing_scheduler #(
    parameter int N_WORKERS        = 4,
    parameter int JOBS_SUBDIVISION = 8,
    parameter int H_RES            = 640,
    parameter int V_RES            = 480,
    parameter int ADDR_W           = 19
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     start,
    input  Types::Circle                             circle_in,
    output logic                                     busy,
    output logic                                     frame_done,
    output Types::Circle                             circle_out,
    output logic [N_WORKERS-1:0]                     worker_activate,
    output logic [N_WORKERS*12-1:0]                  worker_x,
    output logic [11:0]                              worker_y,
    input  logic [N_WORKERS-1:0]                     worker_busy,
    input  logic [N_WORKERS*JOBS_SUBDIVISION*12-1:0] worker_buffer,
    output logic                                     fb_we,
    output logic [ADDR_W-1:0]                        fb_addr,
    output logic [11:0]                              fb_data,
    input  logic                                     fb_ready
);

    localparam int                c_span        = N_WORKERS * JOBS_SUBDIVISION;
    localparam int                c_pix_w       = (c_span > 1) ? $clog2(c_span) : 1;
    localparam logic [c_pix_w-1:0] c_last_pix   = c_pix_w'(c_span - 1);
    localparam logic [11:0]       c_span_step   = 12'(c_span);
    localparam logic [11:0]       c_last_span_x = 12'(H_RES - c_span);
    localparam logic [11:0]       c_last_line   = 12'(V_RES - 1);
    localparam logic [ADDR_W-1:0] c_h_res       = ADDR_W'(H_RES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_DRAIN     = 3'd4,
        S_RELEASE   = 3'd5,
        S_ADVANCE   = 3'd6
    } state_t;

    state_t                  r_state;
    Types::Circle            r_circle;
    logic                    r_busy;
    logic                    r_frame_done;
    logic [N_WORKERS-1:0]    r_activate;
    logic [N_WORKERS*12-1:0] r_worker_x;
    logic [11:0]             r_worker_y;
    logic [11:0]             r_span_x;
    logic [11:0]             r_line_y;
    logic [c_pix_w-1:0]      r_pix;
    logic                    r_fb_we;
    logic [ADDR_W-1:0]       r_fb_addr;
    logic [11:0]             r_fb_data;

    logic [11:0]             w_pix_colour [c_span];
    logic [c_pix_w-1:0]      w_pix_next;
    logic [ADDR_W-1:0]       w_base_addr;
    logic                    w_last_in_line;
    logic                    w_last_span;
    logic [11:0]             w_adv_span_x;
    logic [11:0]             w_adv_line_y;
    logic [11:0]             w_launch_span;
    logic [N_WORKERS*12-1:0] w_launch_x;

    // Pixel p of a span is job p/N_WORKERS of worker p%N_WORKERS; the
    // mapping is fixed, so it folds into wiring rather than a divider.
    generate
        for (genvar p = 0; p < c_span; p++) begin : g_pix_map
            localparam int c_slot = (p % N_WORKERS) * JOBS_SUBDIVISION + p / N_WORKERS;
            assign w_pix_colour[p] = worker_buffer[c_slot*12 +: 12];
        end
    endgenerate

    assign w_pix_next     = r_pix + c_pix_w'(1);
    assign w_base_addr    = ADDR_W'(r_line_y) * c_h_res + ADDR_W'(r_span_x);
    assign w_last_in_line = (r_span_x == c_last_span_x);
    assign w_last_span    = w_last_in_line && (r_line_y == c_last_line);
    assign w_adv_span_x   = w_last_in_line ? 12'd0 : r_span_x + c_span_step;
    assign w_adv_line_y   = w_last_in_line ? r_line_y + 12'd1 : r_line_y;
    assign w_launch_span  = (r_state == S_IDLE) ? 12'd0 : w_adv_span_x;

    generate
        for (genvar i = 0; i < N_WORKERS; i++) begin : g_worker_x
            assign w_launch_x[i*12 +: 12] = w_launch_span + 12'(i);
        end
    endgenerate

    // Worker coordinates are loaded on the same edge that raises activate,
    // so a worker never sees activate high alongside stale coordinates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_circle     <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_activate   <= '0;
            r_worker_x   <= '0;
            r_worker_y   <= '0;
            r_span_x     <= '0;
            r_line_y     <= '0;
            r_pix        <= '0;
            r_fb_we      <= 1'b0;
            r_fb_addr    <= '0;
            r_fb_data    <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A start coinciding with the done pulse belongs to the old frame.
                    if (start && !r_frame_done) begin
                        r_circle   <= circle_in;
                        r_span_x   <= '0;
                        r_line_y   <= '0;
                        r_busy     <= 1'b1;
                        r_activate <= '1;
                        r_worker_x <= w_launch_x;
                        r_worker_y <= '0;
                        r_state    <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (&worker_busy) begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (worker_busy == '0) begin
                        r_pix     <= '0;
                        r_fb_we   <= 1'b1;
                        r_fb_addr <= w_base_addr;
                        r_fb_data <= w_pix_colour[0];
                        r_state   <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_fb_we && fb_ready) begin
                        if (r_pix == c_last_pix) begin
                            r_fb_we <= 1'b0;
                            r_state <= S_RELEASE;
                        end else begin
                            r_pix     <= w_pix_next;
                            r_fb_addr <= r_fb_addr + ADDR_W'(1);
                            r_fb_data <= w_pix_colour[w_pix_next];
                        end
                    end
                end
                S_RELEASE: begin
                    r_activate <= '0;
                    r_state    <= S_ADVANCE;
                end
                S_ADVANCE: begin
                    r_span_x <= w_adv_span_x;
                    r_line_y <= w_adv_line_y;
                    if (w_last_span) begin
                        r_frame_done <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_activate <= '1;
                        r_worker_x <= w_launch_x;
                        r_worker_y <= w_adv_line_y;
                        r_state    <= S_LAUNCH;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy            = r_busy;
    assign frame_done      = r_frame_done;
    assign circle_out      = r_circle;
    assign worker_activate = r_activate;
    assign worker_x        = r_worker_x;
    assign worker_y        = r_worker_y;
    assign fb_we           = r_fb_we;
    assign fb_addr         = r_fb_addr;
    assign fb_data         = r_fb_data;

endmodule
`default_nettype wire
